// File: rtl/arb_rr.sv
// Registered round-robin / fixed-priority request arbiter.
// Presents a one-hot plus encoded grant and holds it until it is acknowledged or the request is withdrawn.
module arb_rr #(
    parameter int  W           = 4,
    parameter bit  FROM_LSB    = 1'b1,
    parameter bit  ROUND_ROBIN = 1'b1,
    localparam int IW          = (W > 1) ? $clog2(W) : 1
) (
    input  logic          i_clk,
    input  logic          i_arst_n,
    input  logic [W-1:0]  i_req,
    input  logic          i_ack,
    output logic          o_gnt_vld,
    output logic [W-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx
);

    typedef enum logic {IDLE, GRANT} state_t;

    // Pointer starts at the low-priority end so the first search begins at the base-priority end.
    localparam logic [IW-1:0] PTR_RST = FROM_LSB ? IW'(W - 1) : '0;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q,   ptr_d;
    logic            vld_q,   vld_d;
    logic [W-1:0]    gnt_q,   gnt_d;
    logic [IW-1:0]   idx_q,   idx_d;

    logic            acked;
    logic            load;
    logic            drop;
    logic [W-1:0]    arb_req;
    logic [IW-1:0]   arb_ptr;
    logic [IW:0]     win;

    // Returns {found, index}. Scans from lowest to highest priority so the last hit is the winner.
    function automatic logic [IW:0] pick(input logic [W-1:0] r, input logic [IW-1:0] p,
                                         input logic use_mask);
        logic          found_m;
        logic          found_a;
        logic [IW-1:0] idx_m;
        logic [IW-1:0] idx_a;
        int            i;
        found_m = 1'b0;
        found_a = 1'b0;
        idx_m   = '0;
        idx_a   = '0;
        for (int k = 0; k < W; k++) begin
            i = FROM_LSB ? (W - 1 - k) : k;
            if (r[i]) begin
                found_a = 1'b1;
                idx_a   = IW'(i);
                if (use_mask && (FROM_LSB ? (i > int'(p)) : (i < int'(p)))) begin
                    found_m = 1'b1;
                    idx_m   = IW'(i);
                end
            end
        end
        return found_m ? {1'b1, idx_m} : {found_a, idx_a};
    endfunction

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        vld_d   = vld_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        load    = 1'b0;
        drop    = 1'b0;
        acked   = (state_q == GRANT) && i_ack;
        // Fixed-priority mode arbitrates on raw requests; rotation mode excludes the acked winner once.
        arb_req = (acked && ROUND_ROBIN) ? (i_req & ~gnt_q) : i_req;
        arb_ptr = (acked && ROUND_ROBIN) ? idx_q : ptr_q;
        win     = pick(arb_req, arb_ptr, ROUND_ROBIN);

        case (state_q)
            IDLE: begin
                if (|i_req) load = 1'b1;
            end
            GRANT: begin
                if (i_ack) begin
                    if (ROUND_ROBIN) ptr_d = idx_q;
                    if (|arb_req) load = 1'b1;
                    else          drop = 1'b1;
                end else if (!(|(i_req & gnt_q))) begin
                    drop = 1'b1;
                end
            end
            default: drop = 1'b1;
        endcase

        if (load) begin
            state_d = GRANT;
            vld_d   = 1'b1;
            idx_d   = win[IW-1:0];
            gnt_d   = W'(1) << win[IW-1:0];
        end else if (drop) begin
            state_d = IDLE;
            vld_d   = 1'b0;
            idx_d   = '0;
            gnt_d   = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= IDLE;
            ptr_q   <= PTR_RST;
            vld_q   <= 1'b0;
            gnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            vld_q   <= vld_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
        end
    end

    assign o_gnt_vld = vld_q;
    assign o_gnt     = gnt_q;
    assign o_gnt_idx = idx_q;

endmodule

// File: tb/tb_arb_rr.sv
// Directed bench for arb_rr: ascending RR, descending RR and fixed-priority instances side by side.
module tb_arb_rr;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_a, req_b, req_c;
    logic       ack_a, ack_b, ack_c;
    logic       vld_a, vld_b, vld_c;
    logic [3:0] gnt_a, gnt_b, gnt_c;
    logic [1:0] idx_a, idx_b, idx_c;
    logic [3:0] cap_a;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    arb_rr #(.W(4), .FROM_LSB(1'b1), .ROUND_ROBIN(1'b1)) u_lsb (
        .i_clk(clk), .i_arst_n(rst_n), .i_req(req_a), .i_ack(ack_a),
        .o_gnt_vld(vld_a), .o_gnt(gnt_a), .o_gnt_idx(idx_a));

    arb_rr #(.W(4), .FROM_LSB(1'b0), .ROUND_ROBIN(1'b1)) u_msb (
        .i_clk(clk), .i_arst_n(rst_n), .i_req(req_b), .i_ack(ack_b),
        .o_gnt_vld(vld_b), .o_gnt(gnt_b), .o_gnt_idx(idx_b));

    arb_rr #(.W(4), .FROM_LSB(1'b1), .ROUND_ROBIN(1'b0)) u_fix (
        .i_clk(clk), .i_arst_n(rst_n), .i_req(req_c), .i_ack(ack_c),
        .o_gnt_vld(vld_c), .o_gnt(gnt_c), .o_gnt_idx(idx_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Structural invariants on the ascending instance, checked after every edge.
    task automatic inv_a();
        chk("inv_onehot", 32'($onehot0(gnt_a)), 32'd1);
        chk("inv_vld_iff_gnt", 32'(gnt_a != 4'b0), 32'(vld_a));
        if (vld_a) chk("inv_idx_bit", 32'(gnt_a[idx_a]), 32'd1);
        chk("inv_subset", 32'(gnt_a & ~cap_a), 32'd0);
    endtask

    task automatic tick();
        cap_a = req_a;
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc=%0d a:req=%b ack=%b vld=%b gnt=%b idx=%0d | b:gnt=%b idx=%0d | c:gnt=%b idx=%0d",
                 cyc, cap_a, ack_a, vld_a, gnt_a, idx_a, gnt_b, idx_b, gnt_c, idx_c);
        inv_a();
    endtask

    initial begin
        rst_n = 1'b0;
        req_a = 4'b0; ack_a = 1'b0;
        req_b = 4'b0; ack_b = 1'b0;
        req_c = 4'b0; ack_c = 1'b0;
        #12;
        chk("reset_vld", 32'(vld_a), 32'd0);
        chk("reset_gnt", 32'(gnt_a), 32'd0);
        chk("reset_idx", 32'(idx_a), 32'd0);
        chk("reset_gnt_b", 32'(gnt_b), 32'd0);
        rst_n = 1'b1;

        // All requesting, acked every cycle: rotation in both directions, fixed priority stays on 1.
        req_a = 4'b1111; ack_a = 1'b1;
        req_b = 4'b1111; ack_b = 1'b1;
        req_c = 4'b1010; ack_c = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_lsb_vld", 32'(vld_a), 32'd1);
            chk("rr_lsb_idx", 32'(idx_a), 32'(k % 4));
            chk("rr_msb_idx", 32'(idx_b), 32'(3 - (k % 4)));
            chk("fixed_gnt", 32'(gnt_c), 32'b0010);
        end
        req_b = 4'b0; req_c = 4'b0;

        // Ack with nothing left: back to idle, pointer now 3.
        req_a = 4'b0000; ack_a = 1'b1;
        tick();
        chk("drain_vld", 32'(vld_a), 32'd0);
        chk("drain_gnt", 32'(gnt_a), 32'd0);
        chk("drain_idx", 32'(idx_a), 32'd0);

        // Hold without ack for five cycles.
        req_a = 4'b0110; ack_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_gnt", 32'(gnt_a), 32'b0010);
        end
        ack_a = 1'b1;
        tick();
        chk("hold_ack_next", 32'(gnt_a), 32'b0100);

        // Withdrawal of the granted request with another pending (pointer is 1 here).
        req_a = 4'b0101; ack_a = 1'b0;
        tick();
        chk("wd_hold", 32'(gnt_a), 32'b0100);
        req_a = 4'b0001;
        tick();
        chk("wd_bubble_vld", 32'(vld_a), 32'd0);
        tick();
        chk("wd_regrant", 32'(gnt_a), 32'b0001);
        req_a = 4'b0000;
        tick();
        chk("wd2_vld", 32'(vld_a), 32'd0);
        // Pointer must still be 1, so the full pattern starts at index 2.
        req_a = 4'b1111;
        tick();
        chk("wd_ptr_kept", 32'(idx_a), 32'd2);
        ack_a = 1'b1;
        tick();
        chk("pre_rst_gnt", 32'(gnt_a), 32'b1000);

        // Asynchronous reset between edges while granting index 3.
        ack_a = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(vld_a), 32'd0);
        chk("arst_gnt", 32'(gnt_a), 32'd0);
        chk("arst_idx", 32'(idx_a), 32'd0);
        #2;
        rst_n = 1'b1;
        req_a = 4'b1111;
        tick();
        chk("post_rst_idx", 32'(idx_a), 32'd0);
        chk("post_rst_vld", 32'(vld_a), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
